rl_step_scheduler: RTL and testbench

//  Time-slices one shared RL Euler-step solver between N_CH independent RL plant channels for HIL.

---
 rtl/rl_pkg.sv | 19 +
 rtl/rl_tick_gen.sv | 33 +++
 rtl/rl_step_scheduler.sv | 144 ++++++++++++++
 tb/tb_rl_step_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_pkg.sv
// Shared definitions for the RL plant scheduler and the Euler-step solver it drives.
package rl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT
  } sched_state_t;

  localparam int RL_W = 32;

  // Default plant constants; the solver datapath uses the same values.
  localparam int RL_R_DEF     = 10;
  localparam int RL_L_DIV_DEF = 64;
  localparam int RL_U0_DEF    = 200;
  localparam int RL_DT_DEF    = 1;

endpackage

// File: rtl/rl_tick_gen.sv
// Simulation-step tick: a 1-cycle pulse every TICK_DIV enabled clock cycles.
module rl_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == CW'(TICK_DIV - 1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rl_step_scheduler.sv
// Time-slices one RL Euler-step solver across N_CH plant channels, one round per simulation tick.
module rl_step_scheduler
  import rl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = RL_W,
  parameter int TICK_DIV = 100,
  parameter int TIMEOUT  = 31,
  parameter int U0_DEF   = RL_U0_DEF,
  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic signed [W-1:0] cfg_u0,
  input  logic [CW-1:0]       rd_ch,
  output logic signed [W-1:0] rd_i,
  output logic                slv_start,
  output logic [CW-1:0]       slv_ch,
  output logic signed [W-1:0] slv_u0,
  output logic signed [W-1:0] slv_i_in,
  input  logic                slv_done,
  input  logic signed [W-1:0] slv_i_out,
  output logic                busy,
  output logic [15:0]         step_cnt,
  output logic                overrun,
  output logic                timeout,
  input  logic                clr_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t        state;
  logic                tick;
  logic [N_CH-1:0]     pending;
  logic [TW-1:0]       wait_cnt;
  logic signed [W-1:0] i_reg  [N_CH];
  logic signed [W-1:0] u0_reg [N_CH];

  function automatic logic [CW-1:0] lowest_set(input logic [N_CH-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  rl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // NOTE: the I/U0 stores are flop arrays, not RAM, so they can and must be reset element by element.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) u0_reg[i] <= W'(U0_DEF);
    end else if (cfg_we) begin
      u0_reg[cfg_ch] <= cfg_u0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_i <= '0;
    else     rd_i <= i_reg[rd_ch];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      slv_start <= 1'b0;
      slv_ch    <= '0;
      slv_u0    <= '0;
      slv_i_in  <= '0;
      step_cnt  <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      for (int i = 0; i < N_CH; i++) i_reg[i] <= '0;
    end else begin
      slv_start <= 1'b0;
      // Clear first so a set event later in this block overrides it.
      if (clr_err) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      if (tick && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            pending <= ch_en;
            if (ch_en == '0) begin
              step_cnt <= step_cnt + 16'd1;
            end else begin
              busy  <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // slv_u0 is latched here so a U0 write during WAIT cannot disturb the step in flight.
          slv_ch    <= lowest_set(pending);
          slv_u0    <= u0_reg[lowest_set(pending)];
          slv_i_in  <= i_reg[lowest_set(pending)];
          slv_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (slv_done) begin
            i_reg[slv_ch]   <= slv_i_out;
            pending[slv_ch] <= 1'b0;
            state           <= NEXT;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout         <= 1'b1;
            pending[slv_ch] <= 1'b0;
            state           <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        NEXT: begin
          if (pending != '0) begin
            state <= ISSUE;
          end else begin
            step_cnt <= step_cnt + 16'd1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rl_step_scheduler.sv
// Directed bench: two scheduler instances (TICK_DIV 100 and 20) each driven by a 9-cycle I+5 solver model.
module tb_rl_step_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        en = 0, cfg_we = 0, clr_err = 0;
  logic [3:0]  ch_en = '0;
  logic [1:0]  cfg_ch = '0, rd_ch = '0, slv_ch;
  logic [31:0] cfg_u0 = '0, rd_i, slv_u0, slv_i_in, slv_i_out = '0;
  logic        slv_start, slv_done = 0, busy, overrun, timeout;
  logic [15:0] step_cnt;

  // Instance B: short tick period to provoke overrun
  logic        en_b = 0, clr_err_b = 0;
  logic [3:0]  ch_en_b = '0;
  logic [1:0]  rd_ch_b = '0, slv_ch_b;
  logic [31:0] rd_i_b, slv_u0_b, slv_i_in_b, slv_i_out_b = '0;
  logic        slv_start_b, slv_done_b = 0, busy_b, overrun_b, timeout_b;
  logic [15:0] step_cnt_b;

  rl_step_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_u0(cfg_u0),
    .rd_ch(rd_ch), .rd_i(rd_i),
    .slv_start(slv_start), .slv_ch(slv_ch), .slv_u0(slv_u0), .slv_i_in(slv_i_in),
    .slv_done(slv_done), .slv_i_out(slv_i_out),
    .busy(busy), .step_cnt(step_cnt), .overrun(overrun), .timeout(timeout),
    .clr_err(clr_err)
  );

  rl_step_scheduler #(.TICK_DIV(20)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .ch_en(ch_en_b),
    .cfg_we(1'b0), .cfg_ch(2'd0), .cfg_u0(32'd0),
    .rd_ch(rd_ch_b), .rd_i(rd_i_b),
    .slv_start(slv_start_b), .slv_ch(slv_ch_b), .slv_u0(slv_u0_b), .slv_i_in(slv_i_in_b),
    .slv_done(slv_done_b), .slv_i_out(slv_i_out_b),
    .busy(busy_b), .step_cnt(step_cnt_b), .overrun(overrun_b), .timeout(timeout_b),
    .clr_err(clr_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  // Solver model A: answers I+5 nine cycles after start, unless the channel is muted.
  int          log_ch[$];
  logic [31:0] log_u0[$], log_i[$], done_u0[$];
  bit          mute_en = 0;
  logic [1:0]  mute_ch = '0;
  bit          a_pend = 0;
  int          a_cnt = 0;
  logic [31:0] a_lat = '0;

  always @(negedge clk) begin
    slv_done = 1'b0;
    if (a_pend) begin
      a_cnt--;
      if (a_cnt == 0) begin
        slv_done  = 1'b1;
        slv_i_out = a_lat + 32'd5;
        a_pend    = 0;
        done_u0.push_back(slv_u0);
      end
    end
    if (slv_start) begin
      log_ch.push_back(int'(slv_ch));
      log_u0.push_back(slv_u0);
      log_i.push_back(slv_i_in);
      if (!(mute_en && slv_ch == mute_ch)) begin
        a_pend = 1;
        a_cnt  = 9;
        a_lat  = slv_i_in;
      end
    end
  end

  // Solver model B: same behaviour, only counts requests.
  bit          b_pend = 0;
  int          b_cnt = 0;
  int          b_starts = 0;
  logic [31:0] b_lat = '0;

  always @(negedge clk) begin
    slv_done_b = 1'b0;
    if (b_pend) begin
      b_cnt--;
      if (b_cnt == 0) begin
        slv_done_b  = 1'b1;
        slv_i_out_b = b_lat + 32'd5;
        b_pend      = 0;
      end
    end
    if (slv_start_b) begin
      b_starts++;
      b_pend = 1;
      b_cnt  = 9;
      b_lat  = slv_i_in_b;
    end
  end

  task automatic clear_logs();
    log_ch.delete(); log_u0.delete(); log_i.delete(); done_u0.delete();
  endtask

  task automatic wait_step(input string tag, input logic [15:0] target);
    for (int k = 0; k < 400 && step_cnt != target; k++) @(negedge clk);
    check(tag, 32'(step_cnt), 32'(target));
  endtask

  task automatic read_i(input logic [1:0] ch, output logic [31:0] val);
    @(negedge clk);
    rd_ch = ch;
    @(negedge clk);
    val = rd_i;
  endtask

  task automatic check_log(input string tag, input int idx, input int exp_ch, input logic [31:0] exp_u0);
    if (idx < log_ch.size()) begin
      check({tag, "_ch"}, 32'(log_ch[idx]), 32'(exp_ch));
      check({tag, "_u0"}, log_u0[idx], exp_u0);
    end else begin
      check({tag, "_missing"}, 32'(log_ch.size()), 32'(idx + 1));
    end
  endtask

  logic [31:0] v;

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_slv_start", 32'(slv_start), 0);
    check("rst_slv_ch",    32'(slv_ch), 0);
    check("rst_slv_u0",    slv_u0, 0);
    check("rst_slv_i_in",  slv_i_in, 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_step_cnt",  32'(step_cnt), 0);
    check("rst_overrun",   32'(overrun), 0);
    check("rst_timeout",   32'(timeout), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      read_i(2'(c), v);
      check($sformatf("rst_rd_i%0d", c), v, 0);
    end

    // 2: single channel, three rounds
    ch_en = 4'b0001;
    en = 1'b1;
    wait_step("t2_step_cnt", 16'd3);
    en = 1'b0;
    check("t2_starts", 32'(log_ch.size()), 3);
    check_log("t2_r0", 0, 0, 32'd200);
    check_log("t2_r2", 2, 0, 32'd200);
    if (log_i.size() == 3) check("t2_i_in_r2", log_i[2], 32'd10);
    read_i(2'd0, v);
    check("t2_rd_i0", v, 32'd15);

    // 3: mask 1011 -> order 0,1,3, channel 2 untouched
    clear_logs();
    ch_en = 4'b1011;
    en = 1'b1;
    wait_step("t3_step_cnt", 16'd4);
    en = 1'b0;
    check("t3_busy_end", 32'(busy), 0);
    check("t3_starts", 32'(log_ch.size()), 3);
    check_log("t3_s0", 0, 0, 32'd200);
    check_log("t3_s1", 1, 1, 32'd200);
    check_log("t3_s2", 2, 3, 32'd200);
    read_i(2'd0, v); check("t3_rd_i0", v, 32'd20);
    read_i(2'd1, v); check("t3_rd_i1", v, 32'd5);
    read_i(2'd2, v); check("t3_rd_i2", v, 32'd0);
    read_i(2'd3, v); check("t3_rd_i3", v, 32'd5);

    // 5: solver silent on ch1 -> timeout, ch2 still stepped
    clear_logs();
    mute_en = 1; mute_ch = 2'd1;
    ch_en = 4'b0110;
    en = 1'b1;
    wait_step("t5_step_cnt", 16'd5);
    en = 1'b0;
    mute_en = 0;
    check("t5_timeout", 32'(timeout), 1);
    check("t5_starts", 32'(log_ch.size()), 2);
    check_log("t5_s0", 0, 1, 32'd200);
    check_log("t5_s1", 1, 2, 32'd200);
    read_i(2'd1, v); check("t5_rd_i1", v, 32'd5);
    read_i(2'd2, v); check("t5_rd_i2", v, 32'd5);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("t5_timeout_clr", 32'(timeout), 0);

    // 6: U0 write during WAIT only affects the next round
    clear_logs();
    ch_en = 4'b0001;
    en = 1'b1;
    for (int k = 0; k < 200 && !slv_start; k++) @(negedge clk);
    check("t6_start_seen", 32'(slv_start), 1);
    repeat (2) @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_u0 = 32'd50;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    check("t6_u0_held", slv_u0, 32'd200);
    wait_step("t6_step_cnt", 16'd7);
    en = 1'b0;
    if (done_u0.size() > 0) check("t6_u0_at_done", done_u0[0], 32'd200);
    else check("t6_done_missing", 32'(done_u0.size()), 1);
    check_log("t6_r0", 0, 0, 32'd200);
    check_log("t6_r1", 1, 0, 32'd50);
    read_i(2'd0, v); check("t6_rd_i0", v, 32'd30);
    check("t6_overrun", 32'(overrun), 0);

    // 4: TICK_DIV=20, four channels -> ticks during the round are overruns
    ch_en_b = 4'b1111;
    en_b = 1'b1;
    for (int k = 0; k < 400 && step_cnt_b == 0; k++) @(negedge clk);
    en_b = 1'b0;
    check("t4_step_cnt", 32'(step_cnt_b), 1);
    check("t4_overrun", 32'(overrun_b), 1);
    check("t4_starts", 32'(b_starts), 4);
    for (int k = 0; k < 400 && busy_b; k++) @(negedge clk);
    check("t4_idle", 32'(busy_b), 0);
    @(negedge clk); rd_ch_b = 2'd3;
    @(negedge clk);
    check("t4_rd_i3", rd_i_b, 32'd5);
    clr_err_b = 1'b1;
    @(negedge clk); clr_err_b = 1'b0;
    check("t4_overrun_clr", 32'(overrun_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
